qspi_flash_responder: RTL and testbench
=======================================

Name: qspi_flash_responder

Overview:
- Synthesizable SPI/QSPI flash target: the responder end of the boot-flash link driven by the SoC QSPI controller.
- Decodes serial commands on spi_sck/spi_cs_n/dq, then streams bytes from a byte-wide memory port (ROM/BRAM image) back to the initiator.
- Used on FPGA bring-up boards with no physical flash, and as an RTL replacement for the behavioural flash model in SoC boot simulations.
- spi_sck and spi_cs_n are oversampled by clk; they are not used as clocks.

Parameters:
- ADDR_W, 24, memory address width; the 24-bit flash address is truncated to ADDR_W LSBs and wraps modulo 2^ADDR_W.
- JEDEC_ID, 24'hEF4018, ID returned by 0x9F, sent MSB byte first.
- DUMMY_CYC, 8, dummy SCK cycles for 0x0B/0x6B.

Ports:
- clk  in  1  system clock; must be at least 8x the spi_sck frequency.
- rst  in  1  asynchronous, active-high reset.
- spi_sck  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
- spi_cs_n  in  1  chip select, active low.
- dq_i  in  4  pad inputs; dq_i[0] = MOSI in single mode.
- dq_o  out  4  pad outputs; dq_o[1] = MISO in single mode.
- dq_oe  out  4  per-bit output enable, 1 = drive.
- mem_rd_en  out  1  one-cycle read strobe.
- mem_addr  out  ADDR_W  read address, valid with mem_rd_en.
- mem_rdata  in  8  read data, valid exactly 1 clk after mem_rd_en.
- busy  out  1  high while the CS-synchronized chip select is active.
- cmd_err  out  1  one-clk pulse when an unsupported opcode completes.

Behaviour:
- Input synchronization:
  - spi_sck and spi_cs_n each pass through a 2-flop synchronizer.
  - Edge detection uses a third flop, giving sck_rise, sck_fall, cs_fall and cs_rise single-clk strobes.
  - dq_i[0] and dq_i[3:0] are sampled through the same 2-flop delay, so data stays aligned with SCK.
- Reset values: dq_o=0, dq_oe=0, mem_rd_en=0, mem_addr=0, busy=0, cmd_err=0, state=IDLE, all counters and shift registers 0.
- States: IDLE, CMD, ADDR, DUMMY, DATA, IGNORE.
- Transitions:
  - IDLE -> CMD on cs_fall; bit counter cleared.
  - CMD: shift dq_i[0] in MSB-first on each sck_rise. After 8 bits, dispatch on the opcode:
    - 0x03 -> ADDR.
    - 0x0B or 0x6B -> ADDR; the fast flag is set, and the quad flag is set for 0x6B only.
    - 0x9F -> DATA in ID mode; byte index 0.
    - any other opcode -> IGNORE; cmd_err pulses.
  - ADDR: 24 bits shifted in on sck_rise, MSB-first. On the 24th bit:
    - fast flag set -> DUMMY.
    - 0x03 -> issue the first fetch and go to DATA.
  - DUMMY: count DUMMY_CYC sck_rise strobes, ignoring data. On the last one, issue the first fetch and go to DATA.
  - DATA (single): on each sck_fall, drive the next bit onto dq_o[1] MSB-first, with dq_oe=4'b0010. The first fall after entering DATA drives bit 7.
  - DATA (quad, 0x6B): on each sck_fall, drive the next nibble onto dq_o[3:0], high nibble first, with dq_oe=4'b1111.
  - IGNORE: dq_oe=0; no fetches; stay until cs_rise.
- Any state -> IDLE on cs_rise:
  - dq_oe=0 in the same clk as cs_rise, so within 3 clk of the pin edge.
  - The partial byte is discarded.
  - busy drops in the same clk.
- Fetch/prefetch:
  - A fetch is mem_rd_en=1 for 1 clk with mem_addr = current address. mem_rdata is captured into a hold register the next clk.
  - At each byte boundary (the sck_fall that drives the first bit or nibble of a byte), the shift register loads from the hold register.
  - At that boundary, the address increments by 1, modulo 2^ADDR_W, and the next fetch issues 1 clk later.
  - Because clk >= 8x SCK, the hold register is always valid before the next byte boundary.
- ID mode (0x9F):
  - Bytes JEDEC_ID[23:16], [15:8], [7:0] are sent in single mode, then the sequence repeats from [23:16].
  - No memory fetches are issued.
- Simultaneous cs_rise and sck edge: cs_rise wins; the sck edge is ignored.
- cs_fall while not in IDLE cannot occur, since cs_rise is required first.
- A glitch on cs_n shorter than 2 clk may be missed; this is acceptable.
- Reset asserted mid-transfer clears everything asynchronously; outputs are undriven immediately.

Test Plan:
- Memory byte[a] = a[7:0]^8'hA5. Send 0x03, addr 0x000010, 32 SCK -> MISO bytes B5,B4,B7,B6; mem_addr sequence 0x10..0x13; dq_oe=4'b0010 only in DATA.
- 0x0B, addr 0x0000FF, 8 dummy, 16 SCK -> bytes 5A,A5 (addr 0xFF then 0x100); dq_oe=0 during the dummy cycles.
- 0x6B, addr 0x000020, 8 dummy, 4 SCK -> nibbles 8,5,8,4 on dq[3:0]; dq_oe=4'b1111.
- Address wrap with ADDR_W=8: 0x03, addr 0x0000FE, read 3 bytes -> 5B,5A,A5; mem_addr FE,FF,00.
- 0x9F, 32 SCK -> EF,40,18,EF; mem_rd_en never asserts.
- Opcode 0x55 -> cmd_err single pulse, dq_oe stays 0. Separately: cs_n rises after bit 3 of a data byte -> dq_oe=0 within 3 clk; the next 0x03 transaction returns correct data. Separately: rst pulsed mid-DATA -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/qspi_flash_responder.sv
// SPI/QSPI flash target: decodes read/ID commands from an oversampled SPI
// bus and streams bytes from a byte-wide memory port back to the initiator.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | chip select inactive, waiting for cs falling edge
// CMD      | shifting in the 8-bit opcode on dq[0]
// ADDR     | shifting in the 24-bit address on dq[0]
// DUMMY    | counting dummy SCK cycles before fast/quad read data
// DATA     | driving read data (single or quad) or the JEDEC ID
// IGNORE   | unsupported opcode, outputs off until cs rises
module qspi_flash_responder #(
    parameter int          ADDR_W    = 24,
    parameter logic [23:0] JEDEC_ID  = 24'hEF4018,
    parameter int          DUMMY_CYC = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sck,
    input  logic              spi_cs_n,
    input  logic [3:0]        dq_i,
    output logic [3:0]        dq_o,
    output logic [3:0]        dq_oe,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              cmd_err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_DUMMY  = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;
    localparam logic [2:0] S_IGNORE = 3'd5;

    localparam logic [7:0]        DUMMY_LAST = 8'(DUMMY_CYC - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

    logic [2:0]        sck_sync;
    logic [2:0]        cs_sync;
    logic [3:0]        dq_s1;
    logic [3:0]        dq_s2;
    logic              sck_rise;
    logic              sck_fall;
    logic              cs_fall;
    logic              cs_rise;
    logic [2:0]        state;
    logic [7:0]        cnt;
    logic [6:0]        op_sr;
    logic [22:0]       addr_sr;
    logic [7:0]        op_next;
    logic [23:0]       addr_next;
    logic              fast;
    logic              quad;
    logic              id_mode;
    logic [1:0]        id_idx;
    logic [ADDR_W-1:0] cur_addr;
    logic              fetch_pend;
    logic              rd_q;
    logic [7:0]        hold;
    logic [7:0]        sh_out;
    logic [7:0]        id_byte;
    logic [7:0]        load_byte;
    logic              unused_bits;

    assign sck_rise  = sck_sync[1] & ~sck_sync[2];
    assign sck_fall  = ~sck_sync[1] & sck_sync[2];
    assign cs_fall   = ~cs_sync[1] & cs_sync[2];
    assign cs_rise   = cs_sync[1] & ~cs_sync[2];
    assign op_next   = {op_sr, dq_s2[0]};
    assign addr_next = {addr_sr, dq_s2[0]};
    assign load_byte = id_mode ? id_byte : hold;
    // Upper data lines are synchronized for alignment but no supported opcode
    // takes quad input; address bits above ADDR_W are dropped.
    assign unused_bits = ^{dq_s2[3:1], addr_next};

    // Select the JEDEC ID byte for the current position in the 3-byte cycle.
    always_comb begin
        id_byte = JEDEC_ID[7:0];
        case (id_idx)
            2'd0:    id_byte = JEDEC_ID[23:16];
            2'd1:    id_byte = JEDEC_ID[15:8];
            default: id_byte = JEDEC_ID[7:0];
        endcase
    end

    // Two-flop synchronizers plus an edge-detect flop; data follows SCK's delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync <= 3'b000;
            cs_sync  <= 3'b000;
            dq_s1    <= 4'h0;
            dq_s2    <= 4'h0;
        end else begin
            sck_sync <= {sck_sync[1:0], spi_sck};
            cs_sync  <= {cs_sync[1:0], spi_cs_n};
            dq_s1    <= dq_i;
            dq_s2    <= dq_s1;
        end
    end

    // Capture read data one clk after the strobe into the hold register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= 1'b0;
            hold <= 8'h00;
        end else begin
            rd_q <= mem_rd_en;
            if (rd_q) begin
                hold <= mem_rdata;
            end
        end
    end

    // Command/address/dummy/data sequencing, output drive and fetch issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= 8'h00;
            op_sr      <= 7'h00;
            addr_sr    <= 23'h0;
            fast       <= 1'b0;
            quad       <= 1'b0;
            id_mode    <= 1'b0;
            id_idx     <= 2'd0;
            cur_addr   <= '0;
            fetch_pend <= 1'b0;
            sh_out     <= 8'h00;
            dq_o       <= 4'h0;
            dq_oe      <= 4'h0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            busy       <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            cmd_err    <= 1'b0;
            mem_rd_en  <= 1'b0;
            fetch_pend <= 1'b0;
            if (fetch_pend) begin
                mem_rd_en <= 1'b1;
                mem_addr  <= cur_addr;
            end
            if (cs_rise) begin
                // Deselect wins over any coincident SCK edge; partial byte dropped.
                state      <= S_IDLE;
                dq_oe      <= 4'h0;
                dq_o       <= 4'h0;
                busy       <= 1'b0;
                fetch_pend <= 1'b0;
                mem_rd_en  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cs_fall) begin
                            state   <= S_CMD;
                            cnt     <= 8'd7;
                            busy    <= 1'b1;
                            fast    <= 1'b0;
                            quad    <= 1'b0;
                            id_mode <= 1'b0;
                            op_sr   <= 7'h00;
                            addr_sr <= 23'h0;
                        end
                    end
                    S_CMD: begin
                        if (sck_rise) begin
                            op_sr <= op_next[6:0];
                            if (cnt == 8'd0) begin
                                case (op_next)
                                    8'h03: begin
                                        state <= S_ADDR;
                                        cnt   <= 8'd23;
                                    end
                                    8'h0B: begin
                                        state <= S_ADDR;
                                        cnt   <= 8'd23;
                                        fast  <= 1'b1;
                                    end
                                    8'h6B: begin
                                        state <= S_ADDR;
                                        cnt   <= 8'd23;
                                        fast  <= 1'b1;
                                        quad  <= 1'b1;
                                    end
                                    8'h9F: begin
                                        state   <= S_DATA;
                                        cnt     <= 8'd0;
                                        id_mode <= 1'b1;
                                        id_idx  <= 2'd0;
                                    end
                                    default: begin
                                        state   <= S_IGNORE;
                                        cmd_err <= 1'b1;
                                    end
                                endcase
                            end else begin
                                cnt <= cnt - 8'd1;
                            end
                        end
                    end
                    S_ADDR: begin
                        if (sck_rise) begin
                            addr_sr <= addr_next[22:0];
                            if (cnt == 8'd0) begin
                                cur_addr <= addr_next[ADDR_W-1:0];
                                if (fast) begin
                                    state <= S_DUMMY;
                                    cnt   <= DUMMY_LAST;
                                end else begin
                                    state     <= S_DATA;
                                    cnt       <= 8'd0;
                                    mem_rd_en <= 1'b1;
                                    mem_addr  <= addr_next[ADDR_W-1:0];
                                end
                            end else begin
                                cnt <= cnt - 8'd1;
                            end
                        end
                    end
                    S_DUMMY: begin
                        if (sck_rise) begin
                            if (cnt == 8'd0) begin
                                state     <= S_DATA;
                                mem_rd_en <= 1'b1;
                                mem_addr  <= cur_addr;
                            end else begin
                                cnt <= cnt - 8'd1;
                            end
                        end
                    end
                    S_DATA: begin
                        if (sck_fall) begin
                            dq_oe <= quad ? 4'b1111 : 4'b0010;
                            if (cnt == 8'd0) begin
                                // Byte boundary: load the next byte, then prefetch.
                                if (quad) begin
                                    dq_o   <= load_byte[7:4];
                                    sh_out <= {load_byte[3:0], 4'h0};
                                    cnt    <= 8'd1;
                                end else begin
                                    dq_o   <= {2'b00, load_byte[7], 1'b0};
                                    sh_out <= {load_byte[6:0], 1'b0};
                                    cnt    <= 8'd7;
                                end
                                if (id_mode) begin
                                    id_idx <= (id_idx == 2'd2) ? 2'd0 : id_idx + 2'd1;
                                end else begin
                                    cur_addr   <= cur_addr + ADDR_ONE;
                                    fetch_pend <= 1'b1;
                                end
                            end else begin
                                if (quad) begin
                                    dq_o   <= sh_out[7:4];
                                    sh_out <= {sh_out[3:0], 4'h0};
                                end else begin
                                    dq_o   <= {2'b00, sh_out[7], 1'b0};
                                    sh_out <= {sh_out[6:0], 1'b0};
                                end
                                cnt <= cnt - 8'd1;
                            end
                        end
                    end
                    S_IGNORE: begin
                        dq_oe <= 4'h0;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Scoreboard bench for qspi_flash_responder: stimulus pushes expected bytes
// and fetch addresses; a clk-negedge monitor pops and compares them.
module tb_qspi_flash_responder;

    localparam int HALF = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_sck = 1'b0;
    logic        cs_n = 1'b1;
    logic        cs8_n = 1'b1;
    logic [3:0]  dq_i = 4'h0;

    logic [3:0]  dq_o_m, dq_oe_m, dq_o8, dq_oe8;
    logic        rd_m, rd8, busy_m, busy8, err_m, err8;
    logic [23:0] addr_m;
    logic [7:0]  addr8;
    logic [7:0]  rdata_m = 8'h00;
    logic [7:0]  rdata8 = 8'h00;

    logic [3:0]  mx_dq_o, mx_dq_oe;
    logic        mx_rd_en, mx_busy, mx_cmd_err;
    logic [23:0] mx_addr;

    logic [7:0]  exp_bytes[$];
    logic [23:0] exp_addrs[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          fetch_total = 0;
    int          err_total = 0;
    int          xfer_id = 0;
    bit          rx_en = 1'b0;
    bit          rx_collect = 1'b0;
    bit          rx_quad = 1'b0;
    bit          fetch_chk = 1'b1;
    bit          sel8 = 1'b0;
    logic [3:0]  exp_oe = 4'h0;

    always #5 clk = ~clk;

    qspi_flash_responder dut (
        .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_cs_n(cs_n), .dq_i(dq_i),
        .dq_o(dq_o_m), .dq_oe(dq_oe_m), .mem_rd_en(rd_m), .mem_addr(addr_m),
        .mem_rdata(rdata_m), .busy(busy_m), .cmd_err(err_m)
    );

    qspi_flash_responder #(.ADDR_W(8)) dut8 (
        .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_cs_n(cs8_n), .dq_i(dq_i),
        .dq_o(dq_o8), .dq_oe(dq_oe8), .mem_rd_en(rd8), .mem_addr(addr8),
        .mem_rdata(rdata8), .busy(busy8), .cmd_err(err8)
    );

    // Synchronous memory images: byte[a] = a[7:0] ^ 0xA5, one clk latency.
    always @(posedge clk) begin
        if (rd_m) rdata_m <= addr_m[7:0] ^ 8'hA5;
        if (rd8)  rdata8  <= addr8 ^ 8'hA5;
    end

    assign mx_dq_o    = sel8 ? dq_o8  : dq_o_m;
    assign mx_dq_oe   = sel8 ? dq_oe8 : dq_oe_m;
    assign mx_rd_en   = sel8 ? rd8    : rd_m;
    assign mx_addr    = sel8 ? {16'h0000, addr8} : addr_m;
    assign mx_busy    = sel8 ? busy8  : busy_m;
    assign mx_cmd_err = sel8 ? err8   : err_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: assembles MISO/quad bytes at SCK rises and checks fetches.
    initial begin : monitor
        logic        sck_prev;
        int          seen_id;
        int          rx_bits;
        logic [7:0]  rx_byte;
        logic [7:0]  eb;
        logic [23:0] ea;
        sck_prev = 1'b0;
        seen_id  = 0;
        rx_bits  = 0;
        rx_byte  = 8'h00;
        forever begin
            @(negedge clk);
            if (xfer_id != seen_id) begin
                seen_id = xfer_id;
                rx_bits = 0;
            end
            if (spi_sck && !sck_prev && rx_en) begin
                chk("dq_oe in data", mx_dq_oe, exp_oe);
                if (rx_collect) begin
                    if (rx_quad) begin
                        rx_byte = {rx_byte[3:0], mx_dq_o};
                        rx_bits += 4;
                    end else begin
                        rx_byte = {rx_byte[6:0], mx_dq_o[1]};
                        rx_bits += 1;
                    end
                    if (rx_bits == 8) begin
                        rx_bits = 0;
                        if (exp_bytes.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL extra byte: got 0x%0h, want none", rx_byte);
                        end else begin
                            eb = exp_bytes.pop_front();
                            chk("data byte", rx_byte, eb);
                        end
                    end
                end
            end
            sck_prev = spi_sck;
            if (mx_rd_en && fetch_chk) begin
                fetch_total++;
                if (exp_addrs.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected fetch: mem_addr 0x%0h, want none", mx_addr);
                end else begin
                    ea = exp_addrs.pop_front();
                    chk("mem_addr", mx_addr, ea);
                end
            end
            if (mx_cmd_err) err_total++;
        end
    end

    task automatic sck_cycle(input logic [3:0] d);
        dq_i = d;
        #(HALF);
        spi_sck = 1'b1;
        #(HALF);
        spi_sck = 1'b0;
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [23:0] adr, input bit has_addr);
        for (int i = 7; i >= 0; i--) sck_cycle({3'b000, op[i]});
        if (has_addr) begin
            for (int i = 23; i >= 0; i--) sck_cycle({3'b000, adr[i]});
        end
    endtask

    task automatic run_xfer(input logic [7:0] op, input logic [23:0] adr, input bit has_addr,
                            input int ndummy, input int ndata, input bit quad,
                            input logic [3:0] oe, input bit collect,
                            input int exp_fetch, input int exp_err, input bit abort);
        int f0;
        int e0;
        @(posedge clk);
        #2;
        f0 = fetch_total;
        e0 = err_total;
        xfer_id++;
        rx_quad    = quad;
        rx_collect = collect;
        exp_oe     = oe;
        if (sel8) cs8_n = 1'b0; else cs_n = 1'b0;
        send_hdr(op, adr, has_addr);
        chk("busy active", mx_busy, 1);
        for (int i = 0; i < ndummy; i++) begin
            dq_i = 4'h0;
            #(HALF);
            spi_sck = 1'b1;
            chk("dq_oe dummy", mx_dq_oe, 0);
            #(HALF);
            spi_sck = 1'b0;
        end
        rx_en = 1'b1;
        for (int i = 0; i < ndata; i++) sck_cycle(4'h0);
        rx_en = 1'b0;
        #(HALF);
        cs_n  = 1'b1;
        cs8_n = 1'b1;
        if (abort) begin
            repeat (3) @(posedge clk);
            #1;
            chk("abort dq_oe", mx_dq_oe, 0);
        end
        repeat (6) @(posedge clk);
        #1;
        chk("busy idle", mx_busy, 0);
        chk("dq_oe idle", mx_dq_oe, 0);
        chk("fetch count", fetch_total - f0, exp_fetch);
        chk("cmd_err pulses", err_total - e0, exp_err);
        chk("bytes left", exp_bytes.size(), 0);
        chk("fetches left", exp_addrs.size(), 0);
    endtask

    initial begin : watchdog
        #(1_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("reset dq_o", dq_o_m, 0);
        chk("reset dq_oe", dq_oe_m, 0);
        chk("reset mem_rd_en", rd_m, 0);
        chk("reset mem_addr", addr_m, 0);
        chk("reset busy", busy_m, 0);
        chk("reset cmd_err", err_m, 0);

        // 0x03 read at 0x10, 4 bytes
        exp_bytes = '{8'hB5, 8'hB4, 8'hB7, 8'hB6};
        exp_addrs = '{24'h10, 24'h11, 24'h12, 24'h13, 24'h14, 24'h15};
        run_xfer(8'h03, 24'h000010, 1'b1, 0, 32, 1'b0, 4'b0010, 1'b1, 6, 0, 1'b0);

        // 0x0B fast read at 0xFF crossing into 0x100
        exp_bytes = '{8'h5A, 8'hA5};
        exp_addrs = '{24'hFF, 24'h100, 24'h101, 24'h102};
        run_xfer(8'h0B, 24'h0000FF, 1'b1, 8, 16, 1'b0, 4'b0010, 1'b1, 4, 0, 1'b0);

        // 0x6B quad read at 0x20: nibbles 8,5,8,4
        exp_bytes = '{8'h85, 8'h84};
        exp_addrs = '{24'h20, 24'h21, 24'h22, 24'h23};
        run_xfer(8'h6B, 24'h000020, 1'b1, 8, 4, 1'b1, 4'b1111, 1'b1, 4, 0, 1'b0);

        // 0x9F JEDEC ID, repeats after three bytes, no fetches
        exp_bytes = '{8'hEF, 8'h40, 8'h18, 8'hEF};
        run_xfer(8'h9F, 24'h0, 1'b0, 0, 32, 1'b0, 4'b0010, 1'b1, 0, 0, 1'b0);

        // Unsupported opcode: one cmd_err pulse, outputs stay off
        run_xfer(8'h55, 24'h0, 1'b0, 0, 8, 1'b0, 4'b0000, 1'b0, 0, 1, 1'b0);

        // Deselect after 3 bits of a data byte
        exp_addrs = '{24'h40, 24'h41};
        run_xfer(8'h03, 24'h000040, 1'b1, 0, 3, 1'b0, 4'b0010, 1'b1, 2, 0, 1'b1);

        // Follow-up read after the abort
        exp_bytes = '{8'hE4, 8'hE7};
        exp_addrs = '{24'h41, 24'h42, 24'h43, 24'h44};
        run_xfer(8'h03, 24'h000041, 1'b1, 0, 16, 1'b0, 4'b0010, 1'b1, 4, 0, 1'b0);

        // ADDR_W=8 instance: address wraps FE, FF, 00
        sel8 = 1'b1;
        exp_bytes = '{8'h5B, 8'h5A, 8'hA5};
        exp_addrs = '{24'hFE, 24'hFF, 24'h00, 24'h01, 24'h02};
        run_xfer(8'h03, 24'h0000FE, 1'b1, 0, 24, 1'b0, 4'b0010, 1'b1, 5, 0, 1'b0);
        sel8 = 1'b0;

        // Reset pulsed in the middle of a data byte
        fetch_chk = 1'b0;
        @(posedge clk);
        #2;
        xfer_id++;
        cs_n = 1'b0;
        send_hdr(8'h03, 24'h000080, 1'b1);
        for (int i = 0; i < 4; i++) sck_cycle(4'h0);
        #20;
        chk("pre-reset dq_oe", dq_oe_m, 4'b0010);
        rst = 1'b1;
        #1;
        chk("mid reset dq_o", dq_o_m, 0);
        chk("mid reset dq_oe", dq_oe_m, 0);
        chk("mid reset mem_rd_en", rd_m, 0);
        chk("mid reset mem_addr", addr_m, 0);
        chk("mid reset busy", busy_m, 0);
        chk("mid reset cmd_err", err_m, 0);
        #30;
        rst = 1'b0;
        cs_n = 1'b1;
        repeat (8) @(posedge clk);
        fetch_chk = 1'b1;

        // Normal read after reset recovery
        exp_bytes = '{8'hA5};
        exp_addrs = '{24'h00, 24'h01, 24'h02};
        run_xfer(8'h03, 24'h000000, 1'b1, 0, 8, 1'b0, 4'b0010, 1'b1, 3, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
